// File: rtl/board_state_engine_pkg.sv
// Shared types, board geometry constants and neighbour helpers for the board state engine.
package board_state_engine_pkg;

    localparam int MAX_DIM = 16;
    localparam int IDX_W   = $clog2(MAX_DIM);
    localparam int CELLS   = MAX_DIM * MAX_DIM;
    localparam int CNT_W   = $clog2(CELLS + 1);
    localparam int CIDX_W  = $clog2(CELLS);

    typedef enum logic {
        OP_FLAG   = 1'b0,
        OP_REVEAL = 1'b1
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_EVAL,
        ST_EXPAND,
        ST_LOST,
        ST_WON
    } board_state_t;

    // Neighbour walk order: row above left to right, same row, row below.
    localparam logic signed [1:0] NBR_DX [8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
    localparam logic signed [1:0] NBR_DY [8] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

    // Flat bit index of cell (x,y) in every board array.
    function automatic logic [CIDX_W-1:0] cell_idx(input logic [IDX_W-1:0] x, input logic [IDX_W-1:0] y);
        return CIDX_W'(y) * CIDX_W'(MAX_DIM) + CIDX_W'(x);
    endfunction

    // Mines among the 8 neighbours of (x,y), ignoring cells outside the active board.
    function automatic logic [3:0] nbr_count(input logic [CELLS-1:0] mine_map,
                                             input logic [IDX_W-1:0]  x,
                                             input logic [IDX_W-1:0]  y,
                                             input logic [IDX_W:0]    dim_x,
                                             input logic [IDX_W:0]    dim_y);
        logic [3:0] cnt;
        int         nx;
        int         ny;
        cnt = '0;
        for (int k = 0; k < 8; k++) begin
            nx = int'(x) + int'(NBR_DX[k]);
            ny = int'(y) + int'(NBR_DY[k]);
            if (nx >= 0 && nx < int'(dim_x) && ny >= 0 && ny < int'(dim_y)) begin
                cnt = cnt + {3'b000, mine_map[CIDX_W'(ny * MAX_DIM + nx)]};
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/board_state_engine_if.sv
// Command handshake from the mouse/control path into the board state engine.
interface board_cmd_if;
    import board_state_engine_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    cmd_op_t          cmd_op;
    logic [IDX_W-1:0] cmd_x;
    logic [IDX_W-1:0] cmd_y;

    modport master (output cmd_valid, output cmd_op, output cmd_x, output cmd_y, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_x, input cmd_y, output cmd_ready);
endinterface

// File: rtl/board_state_engine_cell_fifo.sv
// Show-ahead FIFO of cell coordinates waiting for neighbour evaluation.
module cell_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == OCC_W'(DEPTH));
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write; contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking with synchronous flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Every cell is queued at most once per game, so a push into a full queue means a logic bug.
    always_ff @(posedge clk) begin
        if (rst_n && !i_clear && i_push && !i_pop) begin
            assert (!o_full) else $error("cell_fifo overflow");
        end
    end
endmodule

// File: rtl/board_state_engine.sv
// Per-cell flag/reveal state, command handling and queue-driven flood fill.
module board_state_engine
    import board_state_engine_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_new_game,
    input  logic [IDX_W:0]     i_dim_x,
    input  logic [IDX_W:0]     i_dim_y,
    input  logic [CNT_W-1:0]   i_mines,
    input  logic [CELLS-1:0]   i_mine_arr,
    board_cmd_if.slave         cmd,
    output logic [CELLS-1:0]   o_flag_arr,
    output logic [CELLS-1:0]   o_reveal_arr,
    output logic [CNT_W-1:0]   o_flag_num,
    output logic [CNT_W-1:0]   o_revealed_num,
    output logic [CNT_W-1:0]   o_mines_left,
    output logic               o_exploded,
    output logic [IDX_W-1:0]   o_explode_x,
    output logic [IDX_W-1:0]   o_explode_y,
    output logic               o_game_won,
    output logic               o_busy
);
    board_state_t      r_state;
    board_state_t      w_state_next;
    logic [CELLS-1:0]  r_flag;
    logic [CELLS-1:0]  r_reveal;
    logic [CNT_W-1:0]  r_flag_num;
    logic [CNT_W-1:0]  r_rev_num;
    logic              r_exploded;
    logic [IDX_W-1:0]  r_expl_x;
    logic [IDX_W-1:0]  r_expl_y;
    logic              r_won;
    logic [IDX_W-1:0]  r_cur_x;
    logic [IDX_W-1:0]  r_cur_y;
    logic [2:0]        r_nbr;

    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_cmd_in;
    logic [CIDX_W-1:0] w_cmd_idx;
    logic [CNT_W-1:0]  w_total;
    logic              w_win;
    logic              w_zero;
    logic signed [IDX_W+1:0] w_nx;
    logic signed [IDX_W+1:0] w_ny;
    logic              w_nb_in;
    logic [CIDX_W-1:0] w_nb_idx;
    logic              w_nb_ok;

    logic              w_push;
    logic [2*IDX_W-1:0] w_push_data;
    logic              w_pop;
    logic [2*IDX_W-1:0] w_fifo_dout;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_rev_set;
    logic [CIDX_W-1:0] w_rev_idx;
    logic              w_flag_tgl;
    logic              w_boom;

    cell_fifo #(
        .WIDTH (2 * IDX_W),
        .DEPTH (CELLS)
    ) u_cell_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (i_new_game),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign w_accept  = cmd.cmd_valid && w_cmd_ready && !i_new_game;
    assign w_cmd_in  = ({1'b0, cmd.cmd_x} < i_dim_x) && ({1'b0, cmd.cmd_y} < i_dim_y);
    assign w_cmd_idx = cell_idx(cmd.cmd_x, cmd.cmd_y);
    assign w_total   = CNT_W'(i_dim_x) * CNT_W'(i_dim_y);
    assign w_win     = (r_rev_num == w_total - i_mines);
    assign w_zero    = (nbr_count(i_mine_arr, r_cur_x, r_cur_y, i_dim_x, i_dim_y) == 4'd0);
    assign w_nx      = $signed({2'b00, r_cur_x}) + (IDX_W+2)'(NBR_DX[r_nbr]);
    assign w_ny      = $signed({2'b00, r_cur_y}) + (IDX_W+2)'(NBR_DY[r_nbr]);
    assign w_nb_in   = (w_nx >= 0) && (w_nx < $signed({1'b0, i_dim_x})) &&
                       (w_ny >= 0) && (w_ny < $signed({1'b0, i_dim_y}));
    assign w_nb_idx  = cell_idx(w_nx[IDX_W-1:0], w_ny[IDX_W-1:0]);
    assign w_nb_ok   = w_nb_in && !r_reveal[w_nb_idx] && !r_flag[w_nb_idx];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decision; new_game overrides every state.
    always_comb begin
        w_state_next = r_state;
        if (i_new_game) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && cmd.cmd_op == OP_REVEAL && w_cmd_in &&
                        !r_flag[w_cmd_idx] && !r_reveal[w_cmd_idx]) begin
                        w_state_next = i_mine_arr[w_cmd_idx] ? ST_LOST : ST_POP;
                    end
                end
                ST_POP: begin
                    if (w_fifo_empty) begin
                        w_state_next = w_win ? ST_WON : ST_IDLE;
                    end else begin
                        w_state_next = ST_EVAL;
                    end
                end
                ST_EVAL:   w_state_next = w_zero ? ST_EXPAND : ST_POP;
                ST_EXPAND: w_state_next = (r_nbr == 3'd7) ? ST_POP : ST_EXPAND;
                ST_LOST:   w_state_next = ST_LOST;
                ST_WON:    w_state_next = ST_WON;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Per-state outputs and datapath strobes.
    always_comb begin
        w_cmd_ready = (r_state == ST_IDLE);
        o_busy      = (r_state != ST_IDLE) && (r_state != ST_LOST) && (r_state != ST_WON);
        w_push      = 1'b0;
        w_push_data = {cmd.cmd_y, cmd.cmd_x};
        w_pop       = 1'b0;
        w_rev_set   = 1'b0;
        w_rev_idx   = w_cmd_idx;
        w_flag_tgl  = 1'b0;
        w_boom      = 1'b0;
        if (!i_new_game) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_cmd_in) begin
                        if (cmd.cmd_op == OP_FLAG) begin
                            w_flag_tgl = !r_reveal[w_cmd_idx];
                        end else if (!r_flag[w_cmd_idx] && !r_reveal[w_cmd_idx]) begin
                            w_rev_set = 1'b1;
                            w_boom    = i_mine_arr[w_cmd_idx];
                            w_push    = !i_mine_arr[w_cmd_idx];
                        end
                    end
                end
                ST_POP: w_pop = !w_fifo_empty;
                ST_EXPAND: begin
                    if (w_nb_ok) begin
                        w_rev_set   = 1'b1;
                        w_rev_idx   = w_nb_idx;
                        w_push      = 1'b1;
                        w_push_data = {w_ny[IDX_W-1:0], w_nx[IDX_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Board arrays, counters, sticky status and flood-fill cursor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag     <= '0;
            r_reveal   <= '0;
            r_flag_num <= '0;
            r_rev_num  <= '0;
            r_exploded <= 1'b0;
            r_expl_x   <= '0;
            r_expl_y   <= '0;
            r_won      <= 1'b0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_nbr      <= '0;
        end else if (i_new_game) begin
            r_flag     <= '0;
            r_reveal   <= '0;
            r_flag_num <= '0;
            r_rev_num  <= '0;
            r_exploded <= 1'b0;
            r_expl_x   <= '0;
            r_expl_y   <= '0;
            r_won      <= 1'b0;
            r_nbr      <= '0;
        end else begin
            if (w_flag_tgl) begin
                r_flag[w_cmd_idx] <= !r_flag[w_cmd_idx];
                r_flag_num        <= r_flag[w_cmd_idx] ? r_flag_num - 1'b1 : r_flag_num + 1'b1;
            end
            if (w_rev_set) begin
                r_reveal[w_rev_idx] <= 1'b1;
                if (!w_boom) begin
                    r_rev_num <= r_rev_num + 1'b1;
                end
            end
            if (w_boom) begin
                r_exploded <= 1'b1;
                r_expl_x   <= cmd.cmd_x;
                r_expl_y   <= cmd.cmd_y;
            end
            if (w_pop) begin
                r_cur_x <= w_fifo_dout[IDX_W-1:0];
                r_cur_y <= w_fifo_dout[2*IDX_W-1:IDX_W];
            end
            if (r_state == ST_EVAL) begin
                r_nbr <= '0;
            end else if (r_state == ST_EXPAND) begin
                r_nbr <= r_nbr + 3'd1;
            end
            if (r_state == ST_POP && w_fifo_empty && w_win) begin
                r_won <= 1'b1;
            end
        end
    end

    // A push while the queue is full would silently drop a revealed cell.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && w_fifo_full)) else $error("cell queue full on push");
        end
    end

    assign cmd.cmd_ready  = w_cmd_ready;
    assign o_flag_arr     = r_flag;
    assign o_reveal_arr   = r_reveal;
    assign o_flag_num     = r_flag_num;
    assign o_revealed_num = r_rev_num;
    assign o_mines_left   = (i_mines > r_flag_num) ? i_mines - r_flag_num : '0;
    assign o_exploded     = r_exploded;
    assign o_explode_x    = r_expl_x;
    assign o_explode_y    = r_expl_y;
    assign o_game_won     = r_won;
endmodule

// File: tb/tb_board_state_engine.sv
// Directed scoreboard bench for board_state_engine.
module tb_board_state_engine;
    import board_state_engine_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             new_game;
    logic [IDX_W:0]   dim_x;
    logic [IDX_W:0]   dim_y;
    logic [CNT_W-1:0] mines;
    logic [CELLS-1:0] mine_arr;
    logic [CELLS-1:0] flag_arr;
    logic [CELLS-1:0] reveal_arr;
    logic [CNT_W-1:0] flag_num;
    logic [CNT_W-1:0] revealed_num;
    logic [CNT_W-1:0] mines_left;
    logic             exploded;
    logic [IDX_W-1:0] explode_x;
    logic [IDX_W-1:0] explode_y;
    logic             game_won;
    logic             busy;

    board_cmd_if cmd_if ();

    board_state_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_new_game     (new_game),
        .i_dim_x        (dim_x),
        .i_dim_y        (dim_y),
        .i_mines        (mines),
        .i_mine_arr     (mine_arr),
        .cmd            (cmd_if),
        .o_flag_arr     (flag_arr),
        .o_reveal_arr   (reveal_arr),
        .o_flag_num     (flag_num),
        .o_revealed_num (revealed_num),
        .o_mines_left   (mines_left),
        .o_exploded     (exploded),
        .o_explode_x    (explode_x),
        .o_explode_y    (explode_y),
        .o_game_won     (game_won),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    string            tag_q[$];
    logic [CELLS-1:0] val_q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic expect_v(input string tag, input logic [CELLS-1:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic check_v(input logic [CELLS-1:0] obs);
        string            tag;
        logic [CELLS-1:0] exp_val;
        n_cmp++;
        if (tag_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_underflow observed=%0h expected=<none>", obs);
        end else begin
            tag     = tag_q.pop_front();
            exp_val = val_q.pop_front();
            assert (obs === exp_val) else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_val);
            end
        end
    endtask

    task automatic send(input cmd_op_t op, input int x, input int y);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_x     = IDX_W'(x);
        cmd_if.cmd_y     = IDX_W'(y);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        $display("cmd %s (%0d,%0d) revealed=%0d flags=%0d busy=%0b", op.name(), x, y, revealed_num, flag_num, busy);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        $display("new_game dim=%0dx%0d mines=%0d", dim_x, dim_y, mines);
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        cyc = 0;
        while (busy && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        $display("wait done after %0d cycles busy=%0b", cyc, busy);
    endtask

    logic [CELLS-1:0] e;
    int               cyc;

    initial begin
        rst_n            = 1'b0;
        new_game         = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_FLAG;
        cmd_if.cmd_x     = '0;
        cmd_if.cmd_y     = '0;
        dim_x            = 5'd8;
        dim_y            = 5'd8;
        mines            = CNT_W'(10);
        mine_arr         = '0;
        mine_arr[0]      = 1'b1;
        mine_arr[69]     = 1'b1;

        // reset state
        expect_v("rst_flag_arr", '0);
        expect_v("rst_reveal_arr", '0);
        expect_v("rst_mines_left", CELLS'(10));
        expect_v("rst_cmd_ready", CELLS'(1));
        expect_v("rst_busy", '0);
        expect_v("rst_flag_num", '0);
        #12;
        check_v(flag_arr);
        check_v(reveal_arr);
        check_v(CELLS'(mines_left));
        check_v(CELLS'(cmd_if.cmd_ready));
        check_v(CELLS'(busy));
        check_v(CELLS'(flag_num));
        @(negedge clk);
        rst_n = 1'b1;

        // flag toggle on (2,3) -> bit 3*16+2
        e = '0;
        e[50] = 1'b1;
        expect_v("flag_set_arr", e);
        expect_v("flag_set_mines_left", CELLS'(9));
        expect_v("flag_set_num", CELLS'(1));
        send(OP_FLAG, 2, 3);
        check_v(flag_arr);
        check_v(CELLS'(mines_left));
        check_v(CELLS'(flag_num));
        expect_v("flag_clr_arr", '0);
        expect_v("flag_clr_mines_left", CELLS'(10));
        expect_v("flag_clr_num", '0);
        send(OP_FLAG, 2, 3);
        check_v(flag_arr);
        check_v(CELLS'(mines_left));
        check_v(CELLS'(flag_num));

        // reveal of a flagged cell is ignored
        send(OP_FLAG, 2, 3);
        expect_v("rev_flagged_arr", '0);
        expect_v("rev_flagged_num", '0);
        expect_v("rev_flagged_ready", CELLS'(1));
        expect_v("rev_flagged_flag", e);
        send(OP_REVEAL, 2, 3);
        check_v(reveal_arr);
        check_v(CELLS'(revealed_num));
        check_v(CELLS'(cmd_if.cmd_ready));
        check_v(flag_arr);

        // out-of-range commands have no effect
        expect_v("oor_x_flag", e);
        send(OP_FLAG, 9, 0);
        check_v(flag_arr);
        expect_v("oor_y_reveal", '0);
        expect_v("oor_y_ready", CELLS'(1));
        send(OP_REVEAL, 0, 8);
        check_v(reveal_arr);
        check_v(CELLS'(cmd_if.cmd_ready));

        // mine at (0,0)
        mines = CNT_W'(2);
        pulse_new_game();
        expect_v("ng_flag_clear", '0);
        check_v(flag_arr);
        e = '0;
        e[0] = 1'b1;
        expect_v("boom00_exploded", CELLS'(1));
        expect_v("boom00_x", '0);
        expect_v("boom00_y", '0);
        expect_v("boom00_ready", '0);
        expect_v("boom00_reveal", e);
        send(OP_REVEAL, 0, 0);
        check_v(CELLS'(exploded));
        check_v(CELLS'(explode_x));
        check_v(CELLS'(explode_y));
        check_v(CELLS'(cmd_if.cmd_ready));
        check_v(reveal_arr);
        repeat (3) @(posedge clk);
        #1;
        expect_v("lost_hold_ready", '0);
        check_v(CELLS'(cmd_if.cmd_ready));

        // mine at (5,4) -> bit 69
        pulse_new_game();
        expect_v("ng_after_loss_exploded", '0);
        expect_v("ng_after_loss_ready", CELLS'(1));
        check_v(CELLS'(exploded));
        check_v(CELLS'(cmd_if.cmd_ready));
        e = '0;
        e[69] = 1'b1;
        expect_v("boom54_x", CELLS'(5));
        expect_v("boom54_y", CELLS'(4));
        expect_v("boom54_reveal", e);
        send(OP_REVEAL, 5, 4);
        check_v(CELLS'(explode_x));
        check_v(CELLS'(explode_y));
        check_v(reveal_arr);

        // 8x8 single mine at (7,7): full flood fill wins
        mines = CNT_W'(1);
        mine_arr = '0;
        mine_arr[7*16+7] = 1'b1;
        pulse_new_game();
        e = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                e[y*16+x] = 1'b1;
            end
        end
        e[7*16+7] = 1'b0;
        send(OP_REVEAL, 0, 0);
        wait_idle(3000, cyc);
        expect_v("win_fill_done", '0);
        expect_v("win_reveal", e);
        expect_v("win_revealed_num", CELLS'(63));
        expect_v("win_game_won", CELLS'(1));
        expect_v("win_ready", '0);
        expect_v("win_mines_left", CELLS'(1));
        check_v(CELLS'(busy));
        check_v(reveal_arr);
        check_v(CELLS'(revealed_num));
        check_v(CELLS'(game_won));
        check_v(CELLS'(cmd_if.cmd_ready));
        check_v(CELLS'(mines_left));

        // numbered cell (6,6): single reveal, 4-cycle turnaround
        pulse_new_game();
        e = '0;
        e[6*16+6] = 1'b1;
        expect_v("num_busy_c1", CELLS'(1));
        expect_v("num_reveal_c1", e);
        send(OP_REVEAL, 6, 6);
        check_v(CELLS'(busy));
        check_v(reveal_arr);
        wait_idle(50, cyc);
        expect_v("num_ready_cycle", CELLS'(4));
        expect_v("num_ready", CELLS'(1));
        expect_v("num_revealed_num", CELLS'(1));
        expect_v("num_game_won", '0);
        check_v(CELLS'(cyc + 1));
        check_v(CELLS'(cmd_if.cmd_ready));
        check_v(CELLS'(revealed_num));
        check_v(CELLS'(game_won));

        // 16x16 flood fill aborted by new_game at cycle 20
        dim_x = 5'd16;
        dim_y = 5'd16;
        mine_arr = '0;
        mine_arr[255] = 1'b1;
        pulse_new_game();
        send(OP_REVEAL, 0, 0);
        repeat (19) @(posedge clk);
        #1;
        expect_v("fill_busy_c20", CELLS'(1));
        check_v(CELLS'(busy));
        new_game         = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_FLAG;
        cmd_if.cmd_x     = IDX_W'(1);
        cmd_if.cmd_y     = IDX_W'(1);
        @(posedge clk);
        #1;
        new_game         = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        $display("abort new_game with concurrent flag (1,1)");
        expect_v("abort_reveal", '0);
        expect_v("abort_flag", '0);
        expect_v("abort_revealed_num", '0);
        expect_v("abort_busy", '0);
        expect_v("abort_ready", CELLS'(1));
        expect_v("abort_mines_left", CELLS'(1));
        check_v(reveal_arr);
        check_v(flag_arr);
        check_v(CELLS'(revealed_num));
        check_v(CELLS'(busy));
        check_v(CELLS'(cmd_if.cmd_ready));
        check_v(CELLS'(mines_left));

        // queue must be empty after abort: numbered cell (14,14) reveals alone
        e = '0;
        e[14*16+14] = 1'b1;
        send(OP_REVEAL, 14, 14);
        wait_idle(50, cyc);
        expect_v("post_abort_done", '0);
        expect_v("post_abort_reveal", e);
        expect_v("post_abort_num", CELLS'(1));
        check_v(CELLS'(busy));
        check_v(reveal_arr);
        check_v(CELLS'(revealed_num));

        // asynchronous reset mid-fill clears without a clock edge
        pulse_new_game();
        send(OP_REVEAL, 0, 0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-fill");
        expect_v("arst_reveal", '0);
        expect_v("arst_revealed_num", '0);
        expect_v("arst_busy", '0);
        expect_v("arst_ready", CELLS'(1));
        check_v(reveal_arr);
        check_v(CELLS'(revealed_num));
        check_v(CELLS'(busy));
        check_v(CELLS'(cmd_if.cmd_ready));
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
